// File: rtl/grant_pkg.sv
// Shared grant definitions for the grant beat deserializer.
// Holds the grant type encodings, beat geometry, the deserializer FSM state
// type and the multi-beat classification helper.
package grant_pkg;

    localparam int BEATS  = 4;
    localparam int BEAT_W = 128;

    // Non-builtin grant types
    localparam logic [3:0] GNT_SHARED         = 4'h0;
    localparam logic [3:0] GNT_EXCLUSIVE      = 4'h1;
    localparam logic [3:0] GNT_EXCLUSIVE_ACK  = 4'h2;
    // Builtin grant types
    localparam logic [3:0] GNT_GET_DATA_BEAT  = 4'h3;
    localparam logic [3:0] GNT_GET_DATA_BLOCK = 4'h4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        OUTPUT  = 2'd2
    } state_t;

    // True when the grant carries a full cache line (BEATS beats).
    function automatic logic grant_is_multibeat(input logic builtin, input logic [3:0] g_type);
        if (builtin)
            return g_type == GNT_GET_DATA_BLOCK;
        else
            return (g_type == GNT_SHARED) || (g_type == GNT_EXCLUSIVE);
    endfunction

endpackage

// File: rtl/grant_beat_counter.sv
// Two-bit wrapping beat counter.
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   inc        : advance by one (wraps 3 -> 0)
//   clear      : force to zero (has priority over inc)
//   cnt        : current count
//   last       : cnt == 3, i.e. the next accepted beat completes the line
module grant_beat_counter (
    input  logic       clk,
    input  logic       reset,
    input  logic       inc,
    input  logic       clear,
    output logic [1:0] cnt,
    output logic       last
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cnt <= 2'd0;
        else if (clear)
            cnt <= 2'd0;
        else if (inc)
            cnt <= cnt + 2'd1;
    end

    assign last = (cnt == 2'd3);

endmodule

// File: rtl/grant_beat_deserializer.sv
// Reassembles 128-bit grant beats into one 512-bit cache-line grant.
// Multi-beat grants collect four beats; single-beat and data-less grants
// produce an output record straight from the first beat.
// Ports:
//   clk, reset            : clock, asynchronous active-high reset
//   io_in_*               : beat stream (valid/ready handshake)
//   io_out_*              : assembled grant (valid/ready handshake),
//                           header from the first beat, lane k of data
//                           is bits [128k+127:128k]
//   io_busy               : FSM not idle
//   io_err                : sticky protocol error, present only when
//                           GRANT_DESER_CHECK_EN is defined
// Optional feature macro: GRANT_DESER_CHECK_EN
module grant_beat_deserializer #(
    parameter int BEATS  = grant_pkg::BEATS,
    parameter int BEAT_W = grant_pkg::BEAT_W
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    io_in_valid,
    output logic                    io_in_ready,
    input  logic [1:0]              io_in_bits_addr_beat,
    input  logic [1:0]              io_in_bits_client_xact_id,
    input  logic [3:0]              io_in_bits_manager_xact_id,
    input  logic                    io_in_bits_is_builtin_type,
    input  logic [3:0]              io_in_bits_g_type,
    input  logic [BEAT_W-1:0]       io_in_bits_data,
    output logic                    io_out_valid,
    input  logic                    io_out_ready,
    output logic [1:0]              io_out_bits_client_xact_id,
    output logic [3:0]              io_out_bits_manager_xact_id,
    output logic                    io_out_bits_is_builtin_type,
    output logic [3:0]              io_out_bits_g_type,
    output logic [BEATS*BEAT_W-1:0] io_out_bits_data,
    output logic                    io_out_bits_has_data,
    output logic                    io_busy
`ifdef GRANT_DESER_CHECK_EN
    ,
    output logic                    io_err
`endif
);

    import grant_pkg::*;

    state_t                        state;
    logic [BEATS-1:0][BEAT_W-1:0]  lanes;
    logic [1:0]                    cnt;
    logic                          cnt_last;
    logic                          in_fire;
    logic                          out_fire;
    logic                          first_multi;
    logic                          first_single;
    logic                          cnt_inc;

    assign io_in_ready  = (state != OUTPUT);
    assign in_fire      = io_in_valid && io_in_ready;
    assign out_fire     = io_out_valid && io_out_ready;
    assign first_multi  = grant_is_multibeat(io_in_bits_is_builtin_type, io_in_bits_g_type);
    assign first_single = io_in_bits_is_builtin_type && (io_in_bits_g_type == GNT_GET_DATA_BEAT);

    // The first beat of a multi-beat grant counts as beat 0, so it moves cnt to 1.
    assign cnt_inc = in_fire && (((state == IDLE) && first_multi) || (state == COLLECT));

    grant_beat_counter u_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (cnt_inc),
        .clear (out_fire),
        .cnt   (cnt),
        .last  (cnt_last)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state                       <= IDLE;
            io_out_valid                <= 1'b0;
            io_busy                     <= 1'b0;
            io_out_bits_client_xact_id  <= '0;
            io_out_bits_manager_xact_id <= '0;
            io_out_bits_is_builtin_type <= 1'b0;
            io_out_bits_g_type          <= '0;
            io_out_bits_has_data        <= 1'b0;
            lanes                       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_fire) begin
                        io_out_bits_client_xact_id  <= io_in_bits_client_xact_id;
                        io_out_bits_manager_xact_id <= io_in_bits_manager_xact_id;
                        io_out_bits_is_builtin_type <= io_in_bits_is_builtin_type;
                        io_out_bits_g_type          <= io_in_bits_g_type;
                        io_out_bits_has_data        <= first_multi || first_single;
                        // Fresh line: stale lanes from the previous grant are cleared,
                        // and a data-less grant leaves every lane zero.
                        for (int k = 0; k < BEATS; k++)
                            lanes[k] <= ((k == int'(io_in_bits_addr_beat)) && (first_multi || first_single))
                                        ? io_in_bits_data : '0;
                        io_busy <= 1'b1;
                        if (first_multi) begin
                            state <= COLLECT;
                        end else begin
                            state        <= OUTPUT;
                            io_out_valid <= 1'b1;
                        end
                    end
                end
                COLLECT: begin
                    if (in_fire) begin
                        lanes[io_in_bits_addr_beat] <= io_in_bits_data;
                        if (cnt_last) begin
                            state        <= OUTPUT;
                            io_out_valid <= 1'b1;
                        end
                    end
                end
                OUTPUT: begin
                    if (out_fire) begin
                        state        <= IDLE;
                        io_out_valid <= 1'b0;
                        io_busy      <= 1'b0;
                    end
                end
                default: begin
                    state        <= IDLE;
                    io_out_valid <= 1'b0;
                    io_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign io_out_bits_data = lanes;

`ifdef GRANT_DESER_CHECK_EN
    // Follow-on beats must arrive in order and belong to the captured transaction.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            io_err <= 1'b0;
        else if ((state == COLLECT) && in_fire &&
                 ((io_in_bits_addr_beat != cnt) ||
                  (io_in_bits_client_xact_id != io_out_bits_client_xact_id) ||
                  (io_in_bits_manager_xact_id != io_out_bits_manager_xact_id)))
            io_err <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_grant_beat_deserializer.sv
module tb_grant_beat_deserializer;

    import grant_pkg::*;

    logic         clk = 1'b0;
    logic         reset;
    logic         io_in_valid;
    logic         io_in_ready;
    logic [1:0]   io_in_bits_addr_beat;
    logic [1:0]   io_in_bits_client_xact_id;
    logic [3:0]   io_in_bits_manager_xact_id;
    logic         io_in_bits_is_builtin_type;
    logic [3:0]   io_in_bits_g_type;
    logic [127:0] io_in_bits_data;
    logic         io_out_valid;
    logic         io_out_ready;
    logic [1:0]   io_out_bits_client_xact_id;
    logic [3:0]   io_out_bits_manager_xact_id;
    logic         io_out_bits_is_builtin_type;
    logic [3:0]   io_out_bits_g_type;
    logic [511:0] io_out_bits_data;
    logic         io_out_bits_has_data;
    logic         io_busy;
`ifdef GRANT_DESER_CHECK_EN
    logic         io_err;
`endif

    grant_beat_deserializer dut (
        .clk                         (clk),
        .reset                       (reset),
        .io_in_valid                 (io_in_valid),
        .io_in_ready                 (io_in_ready),
        .io_in_bits_addr_beat        (io_in_bits_addr_beat),
        .io_in_bits_client_xact_id   (io_in_bits_client_xact_id),
        .io_in_bits_manager_xact_id  (io_in_bits_manager_xact_id),
        .io_in_bits_is_builtin_type  (io_in_bits_is_builtin_type),
        .io_in_bits_g_type           (io_in_bits_g_type),
        .io_in_bits_data             (io_in_bits_data),
        .io_out_valid                (io_out_valid),
        .io_out_ready                (io_out_ready),
        .io_out_bits_client_xact_id  (io_out_bits_client_xact_id),
        .io_out_bits_manager_xact_id (io_out_bits_manager_xact_id),
        .io_out_bits_is_builtin_type (io_out_bits_is_builtin_type),
        .io_out_bits_g_type          (io_out_bits_g_type),
        .io_out_bits_data            (io_out_bits_data),
        .io_out_bits_has_data        (io_out_bits_has_data),
        .io_busy                     (io_busy)
`ifdef GRANT_DESER_CHECK_EN
        ,
        .io_err                      (io_err)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]   cid;
        logic [3:0]   mid;
        logic         bi;
        logic [3:0]   gt;
        logic [511:0] data;
        logic         hd;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] bd(input logic [7:0] b);
        return {16{b}};
    endfunction

    task automatic push(input logic [1:0] cid, input logic [3:0] mid, input logic bi,
                        input logic [3:0] gt, input logic [511:0] data, input logic hd);
        exp_t e;
        e.cid = cid; e.mid = mid; e.bi = bi; e.gt = gt; e.data = data; e.hd = hd;
        sb.push_back(e);
    endtask

    // Presents one beat and returns #1 after the edge on which it was accepted.
    task automatic send_beat(input logic [1:0] ab, input logic [1:0] cid, input logic [3:0] mid,
                             input logic bi, input logic [3:0] gt, input logic [127:0] d);
        int n = 0;
        io_in_bits_addr_beat       = ab;
        io_in_bits_client_xact_id  = cid;
        io_in_bits_manager_xact_id = mid;
        io_in_bits_is_builtin_type = bi;
        io_in_bits_g_type          = gt;
        io_in_bits_data            = d;
        io_in_valid                = 1'b1;
        @(negedge clk);
        while (!io_in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("in_ready_wait", io_in_ready, 1);
        @(posedge clk);
        #1 io_in_valid = 1'b0;
    endtask

    // Output monitor: pops the scoreboard on every out fire, and checks that
    // a stalled output holds its value.
    logic         hold;
    logic [511:0] hold_data;
    always @(negedge clk) begin
        if (reset) begin
            hold = 1'b0;
        end else begin
            if (hold) begin
                chk("hold_valid", io_out_valid, 1);
                chk("hold_data", io_out_bits_data, hold_data);
            end
            if (io_out_valid && io_out_ready) begin
                hold = 1'b0;
                if (sb.size() == 0) begin
                    chk("unexpected_out", io_out_valid, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("out_cid", io_out_bits_client_xact_id, e.cid);
                    chk("out_mid", io_out_bits_manager_xact_id, e.mid);
                    chk("out_builtin", io_out_bits_is_builtin_type, e.bi);
                    chk("out_gtype", io_out_bits_g_type, e.gt);
                    chk("out_data", io_out_bits_data, e.data);
                    chk("out_has_data", io_out_bits_has_data, e.hd);
                end
            end else if (io_out_valid) begin
                hold      = 1'b1;
                hold_data = io_out_bits_data;
            end else begin
                hold = 1'b0;
            end
        end
    end

    initial begin
        int n;
        reset                      = 1'b1;
        io_in_valid                = 1'b0;
        io_in_bits_addr_beat       = '0;
        io_in_bits_client_xact_id  = '0;
        io_in_bits_manager_xact_id = '0;
        io_in_bits_is_builtin_type = 1'b0;
        io_in_bits_g_type          = '0;
        io_in_bits_data            = '0;
        io_out_ready               = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", io_out_valid, 0);
        chk("rst_busy", io_busy, 0);
        chk("rst_in_ready", io_in_ready, 1);
        chk("rst_data", io_out_bits_data, 0);
        chk("rst_has_data", io_out_bits_has_data, 0);
        chk("rst_ids", {io_out_bits_client_xact_id, io_out_bits_manager_xact_id}, 0);
`ifdef GRANT_DESER_CHECK_EN
        chk("rst_err", io_err, 0);
`endif
        reset = 1'b0;
        @(posedge clk); #1;

        // 4-beat GNT_SHARED, in order
        push(2'd2, 4'd5, 1'b0, GNT_SHARED, {bd(8'hA3), bd(8'hA2), bd(8'hA1), bd(8'hA0)}, 1'b1);
        for (int k = 0; k < 4; k++)
            send_beat(2'(k), 2'd2, 4'd5, 1'b0, GNT_SHARED, bd(8'hA0 + 8'(k)));
        chk("t1_latency", io_out_valid, 1);
        chk("t1_in_ready_out", io_in_ready, 0);
        @(posedge clk); #1;
        chk("t1_in_ready_after", io_in_ready, 1);
        chk("t1_valid_after", io_out_valid, 0);

        // Single-beat builtin GET_DATA_BEAT into lane 2
        push(2'd1, 4'd3, 1'b1, GNT_GET_DATA_BEAT, {128'h0, 128'hBEEF, 128'h0, 128'h0}, 1'b1);
        send_beat(2'd2, 2'd1, 4'd3, 1'b1, GNT_GET_DATA_BEAT, 128'hBEEF);
        chk("t2_latency", io_out_valid, 1);
        @(posedge clk); #1;

        // Data-less EXCLUSIVE_ACK: data input ignored, lanes all zero
        push(2'd3, 4'd9, 1'b0, GNT_EXCLUSIVE_ACK, 512'h0, 1'b0);
        send_beat(2'd1, 2'd3, 4'd9, 1'b0, GNT_EXCLUSIVE_ACK, 128'hDEAD);
        chk("t3_latency", io_out_valid, 1);
        @(posedge clk); #1;

        // Builtin GET_DATA_BLOCK with a stalled consumer
        io_out_ready = 1'b0;
        push(2'd0, 4'd12, 1'b1, GNT_GET_DATA_BLOCK, {bd(8'hC3), bd(8'hC2), bd(8'hC1), bd(8'hC0)}, 1'b1);
        for (int k = 0; k < 4; k++)
            send_beat(2'(k), 2'd0, 4'd12, 1'b1, GNT_GET_DATA_BLOCK, bd(8'hC0 + 8'(k)));
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t4_stall_valid", io_out_valid, 1);
            chk("t4_stall_in_ready", io_in_ready, 0);
            chk("t4_stall_busy", io_busy, 1);
        end
        @(posedge clk);
        #1 io_out_ready = 1'b1;
        @(posedge clk); #1;
        chk("t4_busy_after", io_busy, 0);
        chk("t4_in_ready_after", io_in_ready, 1);

        // Reset in the middle of a line
        send_beat(2'd0, 2'd1, 4'd1, 1'b0, GNT_SHARED, bd(8'hEE));
        send_beat(2'd1, 2'd1, 4'd1, 1'b0, GNT_SHARED, bd(8'hEF));
        chk("t5_busy_pre", io_busy, 1);
        reset = 1'b1;
        #1;
        chk("t5_busy_rst", io_busy, 0);
        chk("t5_in_ready_rst", io_in_ready, 1);
        chk("t5_data_rst", io_out_bits_data, 0);
        @(posedge clk);
        #1 reset = 1'b0;
        push(2'd3, 4'd6, 1'b0, GNT_EXCLUSIVE, {bd(8'h53), bd(8'h52), bd(8'h51), bd(8'h50)}, 1'b1);
        for (int k = 0; k < 4; k++)
            send_beat(2'(k), 2'd3, 4'd6, 1'b0, GNT_EXCLUSIVE, bd(8'h50 + 8'(k)));
        @(posedge clk); #1;
        push(2'd2, 4'd2, 1'b1, GNT_GET_DATA_BEAT, {384'h0, 128'h1234}, 1'b1);
        send_beat(2'd0, 2'd2, 4'd2, 1'b1, GNT_GET_DATA_BEAT, 128'h1234);
        @(posedge clk); #1;

        // Out-of-order beats 0,2,1,3: lanes follow addr_beat
        push(2'd1, 4'd7, 1'b0, GNT_SHARED, {bd(8'hD3), bd(8'hD2), bd(8'hD1), bd(8'hD0)}, 1'b1);
        send_beat(2'd0, 2'd1, 4'd7, 1'b0, GNT_SHARED, bd(8'hD0));
`ifdef GRANT_DESER_CHECK_EN
        chk("t6_err_first", io_err, 0);
`endif
        send_beat(2'd2, 2'd1, 4'd7, 1'b0, GNT_SHARED, bd(8'hD2));
`ifdef GRANT_DESER_CHECK_EN
        chk("t6_err_second", io_err, 1);
`endif
        send_beat(2'd1, 2'd1, 4'd7, 1'b0, GNT_SHARED, bd(8'hD1));
        send_beat(2'd3, 2'd1, 4'd7, 1'b0, GNT_SHARED, bd(8'hD3));
        chk("t6_latency", io_out_valid, 1);
        @(posedge clk); #1;
`ifdef GRANT_DESER_CHECK_EN
        chk("t6_err_sticky", io_err, 1);
`endif

        n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(posedge clk);
            n++;
        end
        chk("drain", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
